paralelo_a_serial_tx: RTL and testbench

//  TX-side word serializer for the phy_tx path; counterpart of the phy_rx bit-clock/deserialize chain.

---
 rtl/paralelo_a_serial_tx_if.sv | 29 ++
 rtl/paralelo_a_serial_tx.sv | 114 +++++++++++
 tb/tb_paralelo_a_serial_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_a_serial_tx_if.sv
// ---------------------------------------------------------------------------
// paralelo_a_serial_tx_if
// Word-input handshake bundle for the TX serializer.
//   in_data  : parallel word offered by the producer
//   in_valid : producer has a word on in_data
//   in_ready : serializer takes the word this cycle when in_valid=1
// Modports:
//   master : producer side (drives in_data/in_valid, observes in_ready)
//   slave  : serializer side (observes in_data/in_valid, drives in_ready)
// ---------------------------------------------------------------------------
interface paralelo_a_serial_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/paralelo_a_serial_tx.sv
// ---------------------------------------------------------------------------
// paralelo_a_serial_tx
// TX-side word serializer. Runs entirely on the bit clock and shifts WIDTH-bit
// words out MSB first, one bit per cycle. An internal bit counter marks word
// boundaries, so no derived word clock is needed. After reset SYNC_WORDS
// copies of IDLE_WORD are sent; afterwards one data word can be taken per
// word slot, with IDLE_WORD filling any slot that has no word offered.
// Ports:
//   CLK32      : bit clock, all logic on posedge
//   RESET      : synchronous, active-high reset
//   bus        : word handshake (slave side: in_data, in_valid, in_ready)
//   serial_out : serial bit, MSB first
//   word_start : high while serial_out carries bit WIDTH-1 of a word
//   active     : word being shifted out is data (1) or IDLE_WORD (0)
//   synced     : the post-reset idle/sync phase has finished
// ---------------------------------------------------------------------------
module paralelo_a_serial_tx #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
  parameter int unsigned      SYNC_WORDS = 4
) (
  input  logic                  CLK32,
  input  logic                  RESET,
  paralelo_a_serial_tx_if.slave bus,
  output logic                  serial_out,
  output logic                  word_start,
  output logic                  active,
  output logic                  synced
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SYNC_INIT = SW'(SYNC_WORDS - 1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // With a single sync word the first boundary is already a data slot.
  localparam state_t STATE_INIT = (SYNC_WORDS == 1) ? ST_RUN : ST_SYNC;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sync_left_q, sync_left_d;
  logic             active_q, active_d;
  logic             ready;
  logic             boundary;

  // Last bit of the current word: the next word is loaded on this edge.
  assign boundary = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK32) begin
    if (RESET) begin
      state_q     <= STATE_INIT;
      shreg_q     <= IDLE_WORD;
      cnt_q       <= '0;
      sync_left_q <= SYNC_INIT;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sync_left_q <= sync_left_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q << 1;
    cnt_d       = boundary ? '0 : cnt_q + CW'(1);
    sync_left_d = sync_left_q;
    active_d    = active_q;
    ready       = 1'b0;

    if (boundary) begin
      case (state_q)
        ST_SYNC: begin
          shreg_d     = IDLE_WORD;
          active_d    = 1'b0;
          sync_left_d = sync_left_q - SW'(1);
          if (sync_left_q == SW'(1)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Ready is independent of in_valid; a reset cycle never accepts.
          ready = ~RESET;
          if (bus.in_valid) begin
            shreg_d  = bus.in_data;
            active_d = 1'b1;
          end else begin
            shreg_d  = IDLE_WORD;
            active_d = 1'b0;
          end
        end
        default: begin
          state_d = STATE_INIT;
        end
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign serial_out   = shreg_q[WIDTH-1];
  assign word_start   = (cnt_q == '0);
  assign active       = active_q;
  assign synced       = (sync_left_q == '0);

endmodule

// File: tb/tb_paralelo_a_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_paralelo_a_serial_tx
// Self-checking bench for paralelo_a_serial_tx. A word-level model (cycle
// number since reset -> word slot and bit position) checks the default
// instance every cycle; directed sequences with literal expectations pin the
// reset/sync timing, back-to-back data, idle insertion, late valid, reset in
// mid-word, and a small WIDTH=4 / SYNC_WORDS=1 instance.
// ---------------------------------------------------------------------------
module tb_paralelo_a_serial_tx;

  localparam int W    = 8;
  localparam int SYNC = 4;

  logic clk;
  logic rst;

  paralelo_a_serial_tx_if #(.WIDTH(8)) bus ();
  paralelo_a_serial_tx_if #(.WIDTH(4)) bus2 ();

  logic serial_out, word_start, active, synced;
  logic s2_serial, s2_ws, s2_active, s2_synced;

  paralelo_a_serial_tx #(
    .WIDTH     (8),
    .IDLE_WORD (8'hBC),
    .SYNC_WORDS(4)
  ) dut (
    .CLK32     (clk),
    .RESET     (rst),
    .bus       (bus),
    .serial_out(serial_out),
    .word_start(word_start),
    .active    (active),
    .synced    (synced)
  );

  paralelo_a_serial_tx #(
    .WIDTH     (4),
    .IDLE_WORD (4'hC),
    .SYNC_WORDS(1)
  ) dut2 (
    .CLK32     (clk),
    .RESET     (rst),
    .bus       (bus2),
    .serial_out(s2_serial),
    .word_start(s2_ws),
    .active    (s2_active),
    .synced    (s2_synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] w_bc = 8'hBC;
  logic [7:0] w_a5 = 8'hA5;
  logic [7:0] w_3c = 8'h3C;
  logic [3:0] w_c  = 4'hC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d time=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- word-level model, checked on every negedge ------------
  bit         model_on = 0;
  int         t;
  int         m_ph;
  logic       m_exp_ready;
  logic [7:0] cur_word;
  logic       cur_act;

  always @(negedge clk) begin
    if (rst) begin
      check("m_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
      model_on = 1;
      t        = 0;
      cur_word = 8'hBC;
      cur_act  = 1'b0;
    end else if (model_on) begin
      m_ph        = t % W;
      m_exp_ready = (m_ph == W - 1) && (t / W >= SYNC - 1);
      check("m_serial",     {31'd0, serial_out}, {31'd0, cur_word[W-1-m_ph]});
      check("m_word_start", {31'd0, word_start}, {31'd0, m_ph == 0});
      check("m_active",     {31'd0, active},     {31'd0, cur_act});
      check("m_synced",     {31'd0, synced},     {31'd0, t >= (SYNC - 1) * W});
      check("m_ready",      {31'd0, bus.in_ready}, {31'd0, m_exp_ready});
      if (m_ph == W - 1) begin
        if (m_exp_ready && bus.in_valid) begin
          cur_word = bus.in_data;
          cur_act  = 1'b1;
        end else begin
          cur_word = 8'hBC;
          cur_act  = 1'b0;
        end
      end
      t++;
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts RESET for the current cycle; returns inside post-reset cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 4'h0;

    // T1 + T6: reset with no data offered
    do_reset();
    for (int c = 0; c < 32; c++) begin
      run_to(c);
      check("t1_serial",     {31'd0, serial_out},   {31'd0, w_bc[7 - (c % 8)]});
      check("t1_word_start", {31'd0, word_start},   {31'd0, (c % 8) == 0});
      check("t1_synced",     {31'd0, synced},       {31'd0, c >= 24});
      check("t1_ready",      {31'd0, bus.in_ready}, {31'd0, c == 31});
      if (c < 8) begin
        check("t6_serial", {31'd0, s2_serial},     {31'd0, w_c[3 - (c % 4)]});
        check("t6_ws",     {31'd0, s2_ws},         {31'd0, (c % 4) == 0});
        check("t6_ready",  {31'd0, bus2.in_ready}, {31'd0, (c % 4) == 3});
        check("t6_synced", {31'd0, s2_synced},     32'd1);
      end
    end
    run_to(36);

    // T2: valid held from cycle 0, then dropped after the accept at 39
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    do_reset();
    run_to(31);
    check("t2_accept31", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 32; c < 56; c++) begin
      run_to(c);
      if (c == 40) bus.in_valid = 1'b0;
      if (c < 48) begin
        check("t2_serial", {31'd0, serial_out}, {31'd0, w_a5[7 - (c % 8)]});
        check("t2_active", {31'd0, active}, 32'd1);
      end else begin
        check("t3_serial", {31'd0, serial_out}, {31'd0, w_bc[7 - (c % 8)]});
        check("t3_active", {31'd0, active}, 32'd0);
      end
      if (c == 39) check("t2_accept39", {31'd0, bus.in_ready}, 32'd1);
    end

    // T4: valid raised mid-word at 35 waits for the boundary at 39
    bus.in_valid = 1'b0;
    do_reset();
    run_to(35);
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    check("t4_noready35", {31'd0, bus.in_ready}, 32'd0);
    run_to(39);
    check("t4_accept39", {31'd0, bus.in_ready}, 32'd1);
    run_to(40);
    bus.in_valid = 1'b0;
    for (int c = 40; c < 48; c++) begin
      run_to(c);
      check("t4_serial", {31'd0, serial_out}, {31'd0, w_3c[7 - (c % 8)]});
      check("t4_active", {31'd0, active}, 32'd1);
    end
    run_to(48);
    check("t4_idle48", {31'd0, active}, 32'd0);

    // T5: reset in the middle of a data word
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    do_reset();
    run_to(44);
    check("t5_serial44", {31'd0, serial_out}, {31'd0, w_a5[3]});
    check("t5_active44", {31'd0, active}, 32'd1);
    do_reset();  // now absolute cycle 45
    check("t5_serial45", {31'd0, serial_out}, 32'd1);
    check("t5_ws45",     {31'd0, word_start}, 32'd1);
    check("t5_active45", {31'd0, active},     32'd0);
    check("t5_synced45", {31'd0, synced},     32'd0);
    run_to(30);
    check("t5_noready75", {31'd0, bus.in_ready}, 32'd0);
    run_to(31);
    check("t5_ready76", {31'd0, bus.in_ready}, 32'd1);
    run_to(32);
    check("t5_pending_active", {31'd0, active},     32'd1);
    check("t5_pending_msb",    {31'd0, serial_out}, 32'd1);

    // RESET on a RUN boundary must mask in_ready combinationally
    run_to(39);
    rst = 1'b1;
    #1;
    check("rst_masks_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check("rst_b_active", {31'd0, active},     32'd0);
    check("rst_b_ws",     {31'd0, word_start}, 32'd1);
    run_to(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
